// File: rtl/conv_window_3x3_pkg.sv
// Shared definitions for the 3x3 sliding-window generator: window geometry,
// the slot numbering used on the flattened window bus, and the pixel type.
package conv_window_3x3_pkg;

  localparam int WIN     = 3;
  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Slot k = r*WIN + c; r=0 is the top row, c=0 is the left column.
  function automatic int unsigned slot_idx(input int unsigned r, input int unsigned c);
    return r * WIN + c;
  endfunction

endpackage

// File: rtl/conv_window_3x3_counter.sv
// Modulo-N up-counter used to track the raster column and row of the
// incoming pixel stream; wraps to zero after N-1.
module mod_N_counter #(
  parameter int N = 28,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = (count == W'(N - 1));

  // NOTE: clocked state always uses non-blocking (<=) so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/conv_window_3x3.sv
// Streaming 3x3 window generator: two row-deep line buffers feed a 3x3 shift
// window, and every fully populated window is registered for the MAC stage.
module conv_window_3x3
  import conv_window_3x3_pkg::*;
#(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int DATA_W   = 8,
  parameter int COL_BITS = 5,
  parameter int ROW_BITS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_pixel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIN*WIN*DATA_W-1:0]  out_window,
  output logic [ROW_BITS-1:0]        out_row,
  output logic [COL_BITS-1:0]        out_col,
  output logic                       frame_done
);

  typedef logic [DATA_W-1:0] pix_t;

  logic                      accept;
  logic                      transfer;
  logic                      emit;
  logic                      col_at_max;
  logic                      last_win;
  logic [COL_BITS-1:0]       col_cnt;
  logic [ROW_BITS-1:0]       row_cnt;
  logic [WIN*WIN*DATA_W-1:0] win_flat;

  pix_t lb1      [IMG_W];
  pix_t lb2      [IMG_W];
  pix_t win_q    [WIN][WIN];
  pix_t win_next [WIN][WIN];

  // Single output register: upstream may only advance when the slot is free
  // or being drained this cycle.
  assign transfer   = out_valid & out_ready;
  assign in_ready   = ~out_valid | out_ready;
  assign accept     = in_valid & in_ready;
  assign col_at_max = (col_cnt == COL_BITS'(IMG_W - 1));
  assign emit       = accept && (row_cnt >= ROW_BITS'(2)) && (col_cnt >= COL_BITS'(2));
  assign last_win   = (out_row == ROW_BITS'(IMG_H - 3)) && (out_col == COL_BITS'(IMG_W - 3));

  mod_N_counter #(.N(IMG_W), .W(COL_BITS)) u_col_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (accept),
    .count (col_cnt)
  );

  mod_N_counter #(.N(IMG_H), .W(ROW_BITS)) u_row_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (accept & col_at_max),
    .count (row_cnt)
  );

  // NOTE: line buffers and window taps carry no reset; their contents are
  // never emitted before two full rows of the current frame overwrite them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < IMG_W - 1; i++) begin
        lb1[i] <= lb1[i+1];
        lb2[i] <= lb2[i+1];
      end
      lb1[IMG_W-1] <= in_pixel;
      lb2[IMG_W-1] <= lb1[0];
      win_q        <= win_next;
    end
  end

  // lb1[0] is the same column one row up, lb2[0] two rows up.
  // NOTE: every element is assigned on every pass, so no latch is inferred.
  always_comb begin
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        win_next[r][c] = win_q[r][c+1];
      end
    end
    win_next[0][WIN-1] = lb2[0];
    win_next[1][WIN-1] = lb1[0];
    win_next[2][WIN-1] = in_pixel;
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        win_flat[slot_idx(r, c)*DATA_W +: DATA_W] = win_next[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= transfer & last_win;
      if (emit) begin
        out_valid  <= 1'b1;
        out_window <= win_flat;
        out_row    <= row_cnt - ROW_BITS'(2);
        out_col    <= col_cnt - COL_BITS'(2);
      end else if (transfer) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_3x3.sv
// Self-checking bench for conv_window_3x3: random pixel frames are compared
// against a window list built directly from the image array.
module tb_conv_window_3x3;
  import conv_window_3x3_pkg::*;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NWIN = (H - 2) * (W - 2);

  typedef struct {
    int           row;
    int           col;
    logic [71:0]  win;
    int           cyc;
  } win_rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, frame_done;
  pixel_t      in_pixel;
  logic [71:0] out_window;
  logic [4:0]  out_row;
  logic [4:0]  out_col;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_frame_done;
  pixel_t      s_in_pixel;
  logic [71:0] s_out_window;
  logic [1:0]  s_out_row;
  logic [1:0]  s_out_col;

  conv_window_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .COL_BITS(5), .ROW_BITS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  conv_window_3x3 #(.IMG_W(3), .IMG_H(3), .DATA_W(8), .COL_BITS(2), .ROW_BITS(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pixel(s_in_pixel),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_window(s_out_window),
    .out_row(s_out_row), .out_col(s_out_col), .frame_done(s_frame_done)
  );

  int       total = 0;
  int       bad   = 0;
  int       cyc   = 0;
  bit       ov_s;
  win_rec_t got_q[$];
  win_rec_t exp_q[$];
  int       fd_q[$];
  pixel_t   img [0:H-1][0:W-1];

  // One clock of stimulus; records transfers and frame_done pulses.
  task automatic drive(input bit iv, input pixel_t px, input bit ordy, output bit acc);
    win_rec_t rec;
    @(negedge clk);
    in_valid  = iv;
    in_pixel  = px;
    out_ready = ordy;
    #1;
    acc  = iv && (in_ready === 1'b1);
    ov_s = (out_valid === 1'b1);
    if (out_valid === 1'b1 && out_ready) begin
      rec.row = int'(out_row);
      rec.col = int'(out_col);
      rec.win = out_window;
      rec.cyc = cyc;
      got_q.push_back(rec);
    end
    if (frame_done === 1'b1) fd_q.push_back(cyc);
    cyc++;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = pixel_t'((r * 28 + c) & 255);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = pixel_t'($urandom);
  endtask

  // Reference: every 3x3 window of the image, top-left in raster order.
  task automatic model_frame();
    win_rec_t rec;
    for (int r = 0; r <= H - 3; r++) begin
      for (int c = 0; c <= W - 3; c++) begin
        rec.row = r;
        rec.col = c;
        rec.cyc = 0;
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            rec.win[(rr*3+cc)*8 +: 8] = img[r+rr][c+cc];
        exp_q.push_back(rec);
      end
    end
  endtask

  task automatic send_frame(input int pv, input int pr, output bit timed_out);
    int i = 0;
    int n = 0;
    bit acc;
    while (i < H * W && n < 20000) begin
      drive($urandom_range(99) < pv, img[i/W][i%W], $urandom_range(99) < pr, acc);
      if (acc) i++;
      n++;
    end
    timed_out = (i < H * W);
  endtask

  task automatic drain(input int pr, output bit timed_out);
    int n = 0;
    bit acc;
    do begin
      drive(1'b0, '0, ($urandom_range(99) < pr) || (n > 200), acc);
      n++;
    end while (ov_s && n < 500);
    drive(1'b0, '0, 1'b1, acc);
    timed_out = ov_s;
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    fd_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_window !== 72'h0) begin bad++; $display("FAIL reset_out_window got=%h exp=0", out_window); end
    total++; if (out_row !== 5'd0 || out_col !== 5'd0) begin bad++; $display("FAIL reset_row_col got=(%0d,%0d) exp=(0,0)", out_row, out_col); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    total++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin bad++; $display("FAIL reset_small got v=%b r=%b exp v=0 r=1", s_out_valid, s_in_ready); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ramp();
    bit to1, to2;
    int nerr = 0;
    int gaps = 0;
    int first_px[9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    int last_px[9]  = '{213, 214, 215, 241, 242, 243, 13, 14, 15};
    logic [71:0] e_first, e_last;
    for (int k = 0; k < 9; k++) begin
      e_first[k*8 +: 8] = 8'(first_px[k]);
      e_last[k*8 +: 8]  = 8'(last_px[k]);
    end
    clear_logs();
    fill_ramp();
    model_frame();
    send_frame(100, 100, to1);
    drain(100, to2);
    total++; if (to1 || to2) begin bad++; $display("FAIL ramp_timeout got=%b%b exp=00", to1, to2); end
    total++; if (got_q.size() != NWIN) begin bad++; $display("FAIL ramp_count got=%0d exp=%0d", got_q.size(), NWIN); end
    if (got_q.size() == NWIN) begin
      total++;
      if (got_q[0].row != 0 || got_q[0].col != 0 || got_q[0].win !== e_first) begin
        bad++; $display("FAIL ramp_first got=(%0d,%0d) %h exp=(0,0) %h", got_q[0].row, got_q[0].col, got_q[0].win, e_first);
      end
      total++;
      if (got_q[NWIN-1].row != 25 || got_q[NWIN-1].col != 25 || got_q[NWIN-1].win !== e_last) begin
        bad++; $display("FAIL ramp_last got=(%0d,%0d) %h exp=(25,25) %h", got_q[NWIN-1].row, got_q[NWIN-1].col, got_q[NWIN-1].win, e_last);
      end
      for (int k = 1; k < NWIN; k++)
        if (got_q[k].col != 0 && got_q[k].cyc != got_q[k-1].cyc + 1) gaps++;
      total++; if (gaps != 0) begin bad++; $display("FAIL ramp_throughput gaps got=%0d exp=0", gaps); end
      total++;
      if (fd_q.size() != 1 || fd_q[0] != got_q[NWIN-1].cyc + 1) begin
        bad++; $display("FAIL ramp_frame_done pulses=%0d at=%0d exp 1 at %0d", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1, got_q[NWIN-1].cyc + 1);
      end
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size() && nerr < 5; k++) begin
      total++;
      if (got_q[k].row != exp_q[k].row || got_q[k].col != exp_q[k].col || got_q[k].win !== exp_q[k].win) begin
        bad++; nerr++;
        $display("FAIL ramp_win idx=%0d got=(%0d,%0d) %h exp=(%0d,%0d) %h", k, got_q[k].row, got_q[k].col, got_q[k].win, exp_q[k].row, exp_q[k].col, exp_q[k].win);
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc, stalled, to;
    int i = 0;
    int n = 0;
    int nerr = 0;
    int hold_idx = 8 * (W - 2) + 12;
    clear_logs();
    fill_rand();
    model_frame();
    stalled = 1'b0;
    while (i < H * W && n < 20000) begin
      if (i == 10 * W + 15 && !stalled) begin
        stalled = 1'b1;
        for (int s = 0; s < 5; s++) begin
          drive(1'b1, img[i/W][i%W], 1'b0, acc);
          total++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc) begin
            bad++; $display("FAIL bp_stall_handshake cyc=%0d got ready=%b valid=%b exp ready=0 valid=1", s, in_ready, out_valid);
          end
          total++;
          if (int'(out_row) != 8 || int'(out_col) != 12 || out_window !== exp_q[hold_idx].win) begin
            bad++; $display("FAIL bp_stall_hold cyc=%0d got=(%0d,%0d) %h exp=(8,12) %h", s, out_row, out_col, out_window, exp_q[hold_idx].win);
          end
          if (acc) i++;
        end
      end else begin
        drive(1'b1, img[i/W][i%W], 1'b1, acc);
        if (acc) i++;
      end
      n++;
    end
    drain(100, to);
    total++; if (to || i < H * W) begin bad++; $display("FAIL bp_timeout got pixels=%0d exp=%0d", i, H * W); end
    total++; if (got_q.size() != NWIN) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), NWIN); end
    for (int k = 0; k < exp_q.size() && k < got_q.size() && nerr < 5; k++) begin
      total++;
      if (got_q[k].row != exp_q[k].row || got_q[k].col != exp_q[k].col || got_q[k].win !== exp_q[k].win) begin
        bad++; nerr++;
        $display("FAIL bp_win idx=%0d got=(%0d,%0d) %h exp=(%0d,%0d) %h", k, got_q[k].row, got_q[k].col, got_q[k].win, exp_q[k].row, exp_q[k].col, exp_q[k].win);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to1, to2, to3;
    clear_logs();
    fill_ramp();
    model_frame();
    send_frame(100, 100, to1);
    fill_rand();
    model_frame();
    send_frame(100, 100, to2);
    drain(100, to3);
    total++; if (to1 || to2 || to3) begin bad++; $display("FAIL b2b_timeout got=%b%b%b exp=000", to1, to2, to3); end
    total++; if (got_q.size() != 2 * NWIN) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), 2 * NWIN); end
    if (got_q.size() == 2 * NWIN) begin
      total++;
      if (got_q[NWIN].row != 0 || got_q[NWIN].col != 0 || got_q[NWIN].win !== exp_q[NWIN].win) begin
        bad++; $display("FAIL b2b_second_first got=(%0d,%0d) %h exp=(0,0) %h", got_q[NWIN].row, got_q[NWIN].col, got_q[NWIN].win, exp_q[NWIN].win);
      end
      total++;
      if (fd_q.size() != 2 || fd_q[0] != got_q[NWIN-1].cyc + 1 || fd_q[1] != got_q[2*NWIN-1].cyc + 1) begin
        bad++; $display("FAIL b2b_frame_done pulses=%0d exp 2 at %0d,%0d", fd_q.size(), got_q[NWIN-1].cyc + 1, got_q[2*NWIN-1].cyc + 1);
      end
    end
  endtask

  task automatic test_random();
    bit to1, to2, to3;
    int nerr = 0;
    clear_logs();
    fill_rand();
    model_frame();
    send_frame(50, 50, to1);
    fill_rand();
    model_frame();
    send_frame(50, 50, to2);
    drain(50, to3);
    total++; if (to1 || to2 || to3) begin bad++; $display("FAIL rand_timeout got=%b%b%b exp=000", to1, to2, to3); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size() && nerr < 5; k++) begin
      total++;
      if (got_q[k].row != exp_q[k].row || got_q[k].col != exp_q[k].col || got_q[k].win !== exp_q[k].win) begin
        bad++; nerr++;
        $display("FAIL rand_win idx=%0d got=(%0d,%0d) %h exp=(%0d,%0d) %h", k, got_q[k].row, got_q[k].col, got_q[k].win, exp_q[k].row, exp_q[k].col, exp_q[k].win);
      end
    end
    total++; if (fd_q.size() != 2) begin bad++; $display("FAIL rand_frame_done pulses got=%0d exp=2", fd_q.size()); end
  endtask

  task automatic test_mid_reset();
    bit acc, to1, to2;
    int i = 0;
    int n = 0;
    int nerr = 0;
    clear_logs();
    fill_rand();
    while (i <= 10 * W + 7 && n < 2000) begin
      drive(1'b1, img[i/W][i%W], 1'b1, acc);
      if (acc) i++;
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL mrst_clear got valid=%b done=%b exp 0 0", out_valid, frame_done); end
    total++; if (out_row !== 5'd0 || out_col !== 5'd0) begin bad++; $display("FAIL mrst_row_col got=(%0d,%0d) exp=(0,0)", out_row, out_col); end
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    fill_rand();
    model_frame();
    send_frame(80, 80, to1);
    drain(80, to2);
    total++; if (to1 || to2) begin bad++; $display("FAIL mrst_timeout got=%b%b exp=00", to1, to2); end
    total++; if (got_q.size() != NWIN) begin bad++; $display("FAIL mrst_count got=%0d exp=%0d", got_q.size(), NWIN); end
    for (int k = 0; k < exp_q.size() && k < got_q.size() && nerr < 5; k++) begin
      total++;
      if (got_q[k].row != exp_q[k].row || got_q[k].col != exp_q[k].col || got_q[k].win !== exp_q[k].win) begin
        bad++; nerr++;
        $display("FAIL mrst_win idx=%0d got=(%0d,%0d) %h exp=(%0d,%0d) %h", k, got_q[k].row, got_q[k].col, got_q[k].win, exp_q[k].row, exp_q[k].col, exp_q[k].win);
      end
    end
    total++; if (fd_q.size() != 1) begin bad++; $display("FAIL mrst_frame_done pulses got=%0d exp=1", fd_q.size()); end
  endtask

  task automatic test_small();
    pixel_t      sp [0:17];
    logic [71:0] wins [$];
    int          rows [$];
    int          cols [$];
    logic [71:0] e;
    int          i = 0;
    int          n = 0;
    int          fd = 0;
    for (int k = 0; k < 18; k++) sp[k] = pixel_t'($urandom);
    while ((i < 18 || n < 2000) && n < 2000) begin
      @(negedge clk);
      s_in_valid  = (i < 18) && ($urandom_range(99) < 70);
      s_in_pixel  = (i < 18) ? sp[i] : '0;
      s_out_ready = 1'b1;
      #1;
      if (s_out_valid === 1'b1) begin
        wins.push_back(s_out_window);
        rows.push_back(int'(s_out_row));
        cols.push_back(int'(s_out_col));
      end
      if (s_frame_done === 1'b1) fd++;
      if (s_in_valid && s_in_ready === 1'b1) i++;
      n++;
      if (i >= 18 && n < 1990) n = 1990;
    end
    s_in_valid = 1'b0;
    total++; if (i != 18) begin bad++; $display("FAIL small_timeout got pixels=%0d exp=18", i); end
    total++; if (wins.size() != 2) begin bad++; $display("FAIL small_count got=%0d exp=2", wins.size()); end
    for (int f = 0; f < 2 && f < wins.size(); f++) begin
      for (int k = 0; k < 9; k++) e[k*8 +: 8] = sp[f*9 + k];
      total++;
      if (rows[f] != 0 || cols[f] != 0 || wins[f] !== e) begin
        bad++; $display("FAIL small_win frame=%0d got=(%0d,%0d) %h exp=(0,0) %h", f, rows[f], cols[f], wins[f], e);
      end
    end
    total++; if (fd != 2) begin bad++; $display("FAIL small_frame_done pulses got=%0d exp=2", fd); end
  endtask

  initial begin
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_pixel    = '0;
    out_ready   = 1'b0;
    s_in_valid  = 1'b0;
    s_in_pixel  = '0;
    s_out_ready = 1'b0;
    test_reset();
    test_ramp();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
